mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle RISC-V style control unit (Moore FSM plus retired-instruction counter)
//
// Purpose: sequences the shared-memory multi-cycle datapath through fetch, decode,
// address, memory, execute, write-back and branch steps, and counts completed
// instructions.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   opcode, funct3,        instruction fields IR[6:0], IR[14:12], IR[30]
//   funct7_5
//   zero                   ALU zero flag (used by branch resolution)
//   PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
//   ALUSrcA, PCSource      1-bit datapath enables / mux selects
//   ALUSrcB                ALU B select: 00 B, 01 const 4, 10 imm
//   alu_control            0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 unsupported
//   state                  current state code
//   instr_retired          completed-instruction count (wraps)
module mc_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        zero,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  alu_control,
  output logic [3:0]  state,
  output logic [31:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  state_t state_q;
  state_t state_d;

  // Raw write enables before reset gating.
  logic pc_write_s;
  logic mem_write_s;
  logic ir_write_s;
  logic reg_write_s;
  logic retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write_s  = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = 1'b0;
    ALUSrcB     = 2'b00;
    alu_control = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        MemRead    = 1'b1;
        ir_write_s = 1'b1;
        ALUSrcB    = 2'b01;
        pc_write_s = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        ALUSrcB = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_s = 1'b1;
        MemtoReg    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_s = 1'b1;
        IorD        = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        case (funct3)
          3'b000:  alu_control = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_BAD;
        endcase
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        // funct7_5 is part of the immediate here, so it must not select SUB.
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (funct3)
          3'b000:  alu_control = ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_BAD;
        endcase
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        alu_control = ALU_SUB;
        PCSource    = 1'b1;
        // zero comes from this cycle's compare, so PCWrite follows it combinationally.
        case (funct3)
          3'b000:  pc_write_s = zero;
          3'b001:  pc_write_s = ~zero;
          default: pc_write_s = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset blocks every architectural write even before the async clear settles state.
  assign PCWrite  = pc_write_s  & ~reset;
  assign MemWrite = mem_write_s & ~reset;
  assign IRWrite  = ir_write_s  & ~reset;
  assign RegWrite = reg_write_s & ~reset;

  assign state = state_q;

  // Every terminal state hands back to FETCH, so leaving one completes an instruction.
  assign retire = (state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                  (state_q == S_ALU_WB) || (state_q == S_BRANCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_retired <= 32'd0;
    end else if (retire) begin
      instr_retired <= instr_retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - self-checking bench for mc_control_unit
module tb_mc_control_unit;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, PCSource;
  logic [1:0]  ALUSrcB;
  logic [3:0]  alu_control;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .alu_control(alu_control), .state(state),
    .instr_retired(instr_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, iord, mr, mw, irw, m2r, rw, asa, pcs;
    logic [1:0] asb;
    logic [3:0] alu;
  } ctl_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         zm;
    int         lat;
    logic [3:0] key;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input bit rtype);
    if (f3 == 3'b000) return (rtype && f7) ? 4'b0110 : 4'b0010;
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    return 4'b1111;
  endfunction

  // Expected controls for a given state code, straight from the state table.
  function automatic ctl_t exp_ctl(input int st, input logic [2:0] f3, input logic f7, input logic z);
    ctl_t c;
    c = '0;
    c.alu = 4'b0010;
    case (st)
      0: begin c.mr = 1; c.irw = 1; c.asb = 2'b01; c.pcw = 1; end
      1: c.asb = 2'b10;
      2: begin c.asa = 1; c.asb = 2'b10; end
      3: begin c.mr = 1; c.iord = 1; end
      4: begin c.rw = 1; c.m2r = 1; end
      5: begin c.mw = 1; c.iord = 1; end
      6: begin c.asa = 1; c.alu = alu_of(f3, f7, 1'b1); end
      7: begin c.asa = 1; c.asb = 2'b10; c.alu = alu_of(f3, f7, 1'b0); end
      8: c.rw = 1;
      9: begin
        c.asa = 1; c.alu = 4'b0110; c.pcs = 1;
        c.pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic int path_len(input logic [6:0] op);
    case (op)
      7'b0000011: return 5;
      7'b0100011: return 4;
      7'b0110011: return 4;
      7'b0010011: return 4;
      7'b1100011: return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic int path_state(input logic [6:0] op, input int i);
    if (i == 0) return 0;
    if (i == 1) return 1;
    case (op)
      7'b0000011: return (i == 2) ? 2 : (i == 3) ? 3 : 4;
      7'b0100011: return (i == 2) ? 2 : 5;
      7'b0110011: return (i == 2) ? 6 : 8;
      7'b0010011: return (i == 2) ? 7 : 8;
      7'b1100011: return 9;
      default:    return 0;
    endcase
  endfunction

  function automatic ctl_t act_ctl();
    return {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
            ALUSrcA, PCSource, ALUSrcB, alu_control};
  endfunction

  // Called shortly after a falling edge in FETCH; returns shortly after the
  // falling edge of the next FETCH, without consuming that cycle.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int zm, output int lat, output logic [3:0] key);
    int n;
    int exp_st;
    n = path_len(op);
    opcode = op; funct3 = f3; funct7_5 = f7;
    key = 4'd0;
    lat = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      zero = (zm == 2) ? 1'($urandom_range(0, 1)) : (zm == 1);
      #1;
      if (cyc > 0 && state == 4'd0) begin
        lat = cyc;
        break;
      end
      if (cyc == 0) chk("retired_at_fetch", instr_retired, 32'(exp_count));
      exp_st = (cyc < n) ? path_state(op, cyc) : 0;
      chk("state", 32'(state), 32'(exp_st));
      chk("controls", 32'(act_ctl()), 32'(exp_ctl(exp_st, f3, f7, zero)));
      if (state == 4'd6 || state == 4'd7) key = alu_control;
      if (state == 4'd9) key = {3'b000, PCWrite};
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'(n));
    if (n > 2) exp_count++;
  endtask

  vec_t vecs[$];
  ctl_t rst_ctl;
  int lat;
  logic [3:0] key;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{7'b0000011, 3'b010, 1'b1, 0, 5, 4'b0000}); // lw 0xFCE0A103
    vecs.push_back('{7'b0100011, 3'b010, 1'b1, 0, 4, 4'b0000}); // sw 0xFE30A623
    vecs.push_back('{7'b0110011, 3'b000, 1'b0, 0, 4, 4'b0010});
    vecs.push_back('{7'b0110011, 3'b000, 1'b1, 0, 4, 4'b0110});
    vecs.push_back('{7'b0110011, 3'b111, 1'b0, 0, 4, 4'b0000});
    vecs.push_back('{7'b0110011, 3'b110, 1'b1, 0, 4, 4'b0001});
    vecs.push_back('{7'b0110011, 3'b001, 1'b0, 0, 4, 4'b1111});
    vecs.push_back('{7'b0010011, 3'b000, 1'b1, 0, 4, 4'b0010});
    vecs.push_back('{7'b0010011, 3'b111, 1'b1, 0, 4, 4'b0000});
    vecs.push_back('{7'b0010011, 3'b110, 1'b0, 0, 4, 4'b0001});
    vecs.push_back('{7'b0010011, 3'b101, 1'b1, 0, 4, 4'b1111});
    vecs.push_back('{7'b1100011, 3'b000, 1'b0, 1, 3, 4'b0001});
    vecs.push_back('{7'b1100011, 3'b000, 1'b0, 0, 3, 4'b0000});
    vecs.push_back('{7'b1100011, 3'b001, 1'b0, 0, 3, 4'b0001});
    vecs.push_back('{7'b1100011, 3'b001, 1'b0, 1, 3, 4'b0000});
    vecs.push_back('{7'b1100011, 3'b100, 1'b0, 1, 3, 4'b0000});
    vecs.push_back('{7'b1111111, 3'b000, 1'b0, 0, 2, 4'b0000});
    vecs.push_back('{7'b0110111, 3'b000, 1'b0, 0, 2, 4'b0000});

    // Under reset: FETCH selects with every write enable held low.
    rst_ctl = exp_ctl(0, 3'b000, 1'b0, 1'b0);
    rst_ctl.pcw = 1'b0;
    rst_ctl.irw = 1'b0;

    reset = 1'b1; opcode = 7'h7F; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_retired", instr_retired, 32'd0);
    chk("reset_controls", 32'(act_ctl()), 32'(rst_ctl));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zm, lat, key);
      chk("table_latency", 32'(lat), 32'(vecs[i].lat));
      chk("table_key", 32'(key), 32'(vecs[i].key));
    end

    // PCWrite in BRANCH tracks zero within the cycle.
    opcode = 7'b1100011; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b0;
    #1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("branch_state", 32'(state), 32'd9);
    zero = 1'b1;
    #1 chk("beq_zero1_pcwrite", 32'(PCWrite), 32'd1);
    zero = 1'b0;
    #1 chk("beq_zero0_pcwrite", 32'(PCWrite), 32'd0);
    funct3 = 3'b001;
    #1 chk("bne_zero0_pcwrite", 32'(PCWrite), 32'd1);
    @(negedge clk);
    exp_count++;
    #1 chk("after_branch_state", 32'(state), 32'd0);
    chk("after_branch_retired", instr_retired, 32'(exp_count));

    for (int r = 0; r < 300; r++) begin
      logic [6:0] op;
      case ($urandom_range(0, 5))
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: op = 7'b1100011;
        default: op = 7'($urandom_range(0, 127));
      endcase
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, lat, key);
    end

    // Reset pulsed in MEM_READ aborts the load before MEM_WB.
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b1; zero = 1'b0;
    #1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 chk("pre_reset_state", 32'(state), 32'd3);
    chk("pre_reset_retired", instr_retired, 32'(exp_count));
    #1 reset = 1'b1;
    #1 chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_retired", instr_retired, 32'd0);
    chk("async_reset_controls", 32'(act_ctl()), 32'(rst_ctl));
    @(negedge clk);
    #1 chk("held_reset_state", 32'(state), 32'd0);
    chk("held_reset_controls", 32'(act_ctl()), 32'(rst_ctl));
    @(posedge clk);
    #1 reset = 1'b0;
    exp_count = 0;
    @(negedge clk);

    run_instr(7'b1111111, 3'b000, 1'b0, 0, lat, key);
    run_instr(7'b0000011, 3'b010, 1'b1, 0, lat, key);
    run_instr(7'b0100011, 3'b010, 1'b1, 0, lat, key);
    #1 chk("final_retired", instr_retired, 32'(exp_count));
    chk("final_state", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
